// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry, default bit timing,
// and the 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (UART rx, PS/2 clk/data).
// RESET_VAL sets the line's idle level so a reset never produces a false edge.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with bit-centre sampling, frame-error detection and break handling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre (+1 cycle latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       finish,
    output logic       frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W   = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE_LAG = 1;
`else
    localparam int DECIDE_LAG = 0;
`endif

    // The lag shifts the start decision by one cycle; every later bit inherits the shift,
    // so data/stop still decide at the end of their bit period.
    localparam logic [TIMER_W-1:0] START_AT = TIMER_W'(CLKS_PER_BIT / 2 - 1 + DECIDE_LAG);
    localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic rx_s;
    logic sample;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
        sample = maj3(hist_q[1], hist_q[0], rx_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign sample = rx_s;
`endif

    uart_rx_state_t         state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   finish_q, finish_d;
    logic                   frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TIMER_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        finish_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (timer_q == START_AT) begin
                    timer_d = '0;
                    state_d = sample ? IDLE : DATA;
                end
            end

            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d   = '0;
                    shift_d   = {sample, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    if (sample) begin
                        data_d   = shift_q;
                        finish_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end

            BREAK: begin
                // A held-low line must go idle before another start bit is accepted.
                timer_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            finish_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            finish_q    <= finish_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign finish    = finish_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: vector table, corner sequences
// and a randomized frame stream checked against a byte-level model.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 155;
`else
    localparam int LAT = 154;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       finish;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .finish   (finish),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         fin;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] prev_data = 8'h00;
    int         last_ev   = 0;

    // Strobe capture plus the always-on output properties.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data = 8'h00;
        end else begin
            if (finish || frame_err) begin
                ev_t e;
                e.cyc = cyc;
                e.fin = finish;
                e.err = frame_err;
                e.d   = data;
                evq.push_back(e);
                checks++;
                if (finish && frame_err) begin
                    errors++;
                    $display("FAIL strobe_exclusive: finish=%0b frame_err=%0b, required not both", finish, frame_err);
                end
            end
            if (data !== prev_data) begin
                checks++;
                if (finish !== 1'b1) begin
                    errors++;
                    $display("FAIL data_hold: data changed %02h->%02h without finish", prev_data, data);
                end
                prev_data = data;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit glitch, output int start);
        logic [9:0] bits;
        bits  = {stop, b, 1'b0};
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < C; c++) begin
                rx = bits[i] ^ (glitch && c == 9);
                tick();
            end
        end
    endtask

    task automatic check_frame(input string name, input bit exp_fin, input bit exp_err,
                               input logic [7:0] exp_d, input int start, input bit b2b);
        ev_t e;
        int  lat;
        check({name, " events"}, evq.size(), (exp_fin || exp_err) ? 1 : 0);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check({name, " finish"}, int'(e.fin), int'(exp_fin));
            check({name, " frame_err"}, int'(e.err), int'(exp_err));
            check({name, " data"}, int'(e.d), int'(exp_d));
            lat = e.cyc - start;
            checks++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, expected %0d +/- 1", name, lat, LAT);
            end
            if (b2b) check({name, " spacing"}, e.cyc - last_ev, 10 * C);
            last_ev = e.cyc;
        end
        evq.delete();
    endtask

    typedef struct {
        logic [7:0] b;
        bit         stop;
        int         pre_gap;
        int         post_low;
        bit         exp_fin;
        bit         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] model_data;
        int         start;
        bit         prev_good;

        vecs[0] = '{8'h0B, 1'b1, 10, 0,  1'b1, 1'b0, 8'h0B};
        vecs[1] = '{8'h00, 1'b1, 10, 0,  1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,  0,  1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 10, 40, 1'b0, 1'b1, 8'hFF};
        vecs[4] = '{8'hA5, 1'b1, 8,  0,  1'b1, 1'b0, 8'hA5};
        vecs[5] = '{8'h81, 1'b1, 0,  0,  1'b1, 1'b0, 8'h81};

        // Reset state
        #1;
        check("reset data", int'(data), 0);
        check("reset finish", int'(finish), 0);
        check("reset frame_err", int'(frame_err), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            idle(vecs[i].pre_gap);
            send_frame(vecs[i].b, vecs[i].stop, 1'b0, start);
            if (vecs[i].post_low > 0) begin
                rx = 1'b0;
                repeat (vecs[i].post_low) tick();
            end
            check_frame($sformatf("vec%0d", i), vecs[i].exp_fin, vecs[i].exp_err,
                        vecs[i].exp_data, start, vecs[i].pre_gap == 0);
        end
        model_data = 8'h81;

        // Short low glitch on an idle line, then a frame 11 cycles after it began
        idle(10);
        rx = 1'b0;
        repeat (3) tick();
        idle(8);
        check("glitch events", evq.size(), 0);
        send_frame(8'h3A, 1'b1, 1'b0, start);
        check_frame("after_glitch", 1'b1, 1'b0, 8'h3A, start, 1'b0);
        model_data = 8'h3A;

        // Reset during data bit 4 of 0x77
        idle(10);
        start = cyc;
        for (int k = 0; k < 5 * C + C / 2; k++) begin
            logic [9:0] bits;
            bits = {1'b1, 8'h77, 1'b0};
            rx   = bits[k / C];
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midreset data", int'(data), 0);
        check("midreset finish", int'(finish), 0);
        check("midreset frame_err", int'(frame_err), 0);
        rx = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        idle(5);
        check("midreset events", evq.size(), 0);
        send_frame(8'h3C, 1'b1, 1'b0, start);
        check_frame("after_reset", 1'b1, 1'b0, 8'h3C, start, 1'b0);
        model_data = 8'h3C;

`ifdef UART_RX_MAJORITY_EN
        idle(10);
        send_frame(8'h0F, 1'b1, 1'b1, start);
        check_frame("majority_glitch", 1'b1, 1'b0, 8'h0F, start, 1'b0);
        model_data = 8'h0F;
`endif

        // Randomized frame stream against a byte-level model
        prev_good = 1'b0;
        idle(10);
        for (int n = 0; n < 40; n++) begin
            int         kind;
            int         gap;
            logic [7:0] b;
            bit         stop;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
                idle(12);
                check($sformatf("rnd%0d glitch events", n), evq.size(), 0);
                prev_good = 1'b0;
            end else begin
                b    = 8'($urandom);
                stop = (kind != 1);
                gap  = (evq.size() == 0 && !prev_good && n > 0) ? $urandom_range(2, 10)
                                                                : $urandom_range(0, 6);
                if (!prev_good) gap = gap + 2;
                idle(gap);
                send_frame(b, stop, 1'b0, start);
                if (!stop) begin
                    rx = 1'b0;
                    repeat ($urandom_range(0, 20)) tick();
                end
                check_frame($sformatf("rnd%0d", n), stop, !stop, stop ? b : model_data,
                            start, prev_good && gap == 0);
                if (stop) model_data = b;
                prev_good = stop;
            end
        end
        idle(20);
        check("final data", int'(data), int'(model_data));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
